// File: rtl/apb4_sram_pkg.sv
// Shared types and helpers for the APB4 SRAM controller.
// BYTES/OFS_W describe the default 32-bit build.
package apb4_sram_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

  localparam int DEF_DATA_W = 32;
  localparam int BYTES      = DEF_DATA_W / 8;
  localparam int OFS_W      = $clog2(BYTES);

  // Even parity: the stored bit makes the byte plus parity XOR to zero.
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/spram_be.sv
// Generic single-port RAM with per-lane write enables.
// The read data passes through an RD_LAT-deep register pipeline.
module spram_be #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BYTES  = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BYTES-1:0]  be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int LANE_W = DATA_W / BYTES;

  logic [DATA_W-1:0] mem  [2**ADDR_W];
  logic [DATA_W-1:0] pipe [RD_LAT];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) mem[addr][i*LANE_W +: LANE_W] <= din[i*LANE_W +: LANE_W];
      end
    end
    if (en && !we) pipe[0] <= mem[addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign dout = pipe[RD_LAT-1];

endmodule

// File: rtl/apb4_sram_ctrl.sv
// APB4 slave in front of a byte-enable SRAM with decode-error response.
// Define APB_SRAM_PARITY_EN to store and check one even-parity bit per byte.
//
// state | meaning
// IDLE  | waiting for a setup phase
// WR    | write issued to SRAM, completion cycle
// RD    | read issued, counting down the SRAM latency
// RESP  | completion cycle for reads and decode errors
module apb4_sram_ctrl
  import apb4_sram_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                psel,
  input  logic                penable,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic                pwrite,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int IW = ADDR_W - OW;
  localparam int AW = $clog2(DEPTH);
`ifdef APB_SRAM_PARITY_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif
  localparam int MW = NB * LW;
  localparam logic [IW:0] DEPTH_L = (IW+1)'(DEPTH);

  state_t            state, state_n;
  logic [AW-1:0]     addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [NB-1:0]     strb_q, strb_n;
  logic [1:0]        cnt, cnt_n;
  logic [DATA_W-1:0] prdata_n;
  logic              pready_n, pslverr_n;

  logic [IW-1:0]     idx;
  logic              dec_err, accept;
  logic              ram_en, ram_we;
  logic [MW-1:0]     ram_din, ram_dout;
  logic [DATA_W-1:0] rd_data;
  logic              par_err;

  assign idx     = paddr[ADDR_W-1:OW];
  assign dec_err = ({1'b0, idx} >= DEPTH_L) || (paddr[OW-1:0] != '0);
  assign accept  = psel && !penable && (state != RD);
  assign ram_we  = (state == WR);
  assign ram_en  = ram_we || ((state == RD) && (cnt == 2'(RD_LAT)));

  // Lane packing: each SRAM lane is a data byte, optionally topped by its parity bit.
  always_comb begin
    ram_din = '0;
    rd_data = '0;
    par_err = 1'b0;
    for (int i = 0; i < NB; i++) begin
`ifdef APB_SRAM_PARITY_EN
      ram_din[i*LW +: LW] = {even_par(wdata_q[i*8 +: 8]), wdata_q[i*8 +: 8]};
      par_err = par_err | (^ram_dout[i*LW +: LW]);
`else
      ram_din[i*LW +: LW] = wdata_q[i*8 +: 8];
`endif
      rd_data[i*8 +: 8] = ram_dout[i*LW +: 8];
    end
  end

  spram_be #(
    .ADDR_W (AW),
    .DATA_W (MW),
    .BYTES  (NB),
    .RD_LAT (RD_LAT)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .be   (strb_q),
    .addr (addr_q),
    .din  (ram_din),
    .dout (ram_dout)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      cnt     <= '0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      state   <= state_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      strb_q  <= strb_n;
      cnt     <= cnt_n;
      prdata  <= prdata_n;
      pready  <= pready_n;
      pslverr <= pslverr_n;
    end
  end

  always_comb begin
    state_n   = state;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    strb_n    = strb_q;
    cnt_n     = cnt;
    prdata_n  = prdata;
    pready_n  = 1'b0;
    pslverr_n = 1'b0;

    case (state)
      RD: begin
        if (!psel) begin
          state_n = IDLE;
        end else if (cnt == 2'd0) begin
          state_n   = RESP;
          prdata_n  = rd_data;
          pready_n  = 1'b1;
          pslverr_n = par_err;
        end else begin
          cnt_n = cnt - 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Completion cycles also take a new setup phase, so transfers chain without a gap.
    if (accept) begin
      addr_n  = idx[AW-1:0];
      wdata_n = pwdata;
      strb_n  = pstrb;
      if (dec_err) begin
        state_n   = RESP;
        pready_n  = 1'b1;
        pslverr_n = 1'b1;
        prdata_n  = '0;
      end else if (pwrite) begin
        state_n  = WR;
        pready_n = 1'b1;
      end else begin
        state_n = RD;
        cnt_n   = 2'(RD_LAT);
      end
    end
  end

endmodule
